// File: rtl/imem_responder.sv
// Instruction-fetch responder: valid/ready request in, programmable-latency read of a
// word-addressed instruction store, valid/ready response out, with flush, faults and a loader port.
module imem_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int LATENCY       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDRESS_WIDTH-1:0]       req_addr,
    input  logic                           flush,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_instr,
    output logic [ADDRESS_WIDTH-1:0]       rsp_addr,
    output logic                           rsp_fault,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]          ld_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                   state, state_nx;
    logic [3:0]               cnt, cnt_nx;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic                     accept;
    logic                     capture;
    logic [IDX_W-1:0]         word_idx;
    logic                     addr_fault;
    logic [DATA_WIDTH-1:0]    store [DEPTH_WORDS];

    // Ready is the only path that sees rsp_ready/flush combinationally; rsp_valid is pure state.
    assign req_ready = rst && !flush && (state == IDLE || (state == RESP && rsp_ready));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);

    // DEPTH_WORDS is a power of two, so "word index >= DEPTH_WORDS" means any upper bit set.
    assign word_idx   = lat_addr[IDX_W+1:2];
    assign addr_fault = (lat_addr[1:0] != 2'b00) ||
                        (lat_addr[ADDRESS_WIDTH-1:IDX_W+2] != '0);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_INIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx = RESP;
                    capture  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (rsp_ready) begin
                    if (accept) begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            rsp_instr <= '0;
            rsp_addr  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_addr <= req_addr;
            end
            if (capture) begin
                rsp_addr  <= lat_addr;
                rsp_fault <= addr_fault;
                rsp_instr <= addr_fault ? NOP_INSTR : store[word_idx];
            end
        end
    end

    // NOTE: the instruction store has no reset so it maps onto plain RAM; a same-edge
    // capture therefore sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            store[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed vector table, hand-written corner
// sequences and randomized traffic, all compared every cycle against a transaction-level model.
module tb_imem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int IW    = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          flush;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_instr;
    logic [AW-1:0] rsp_addr;
    logic          rsp_fault;
    logic          ld_en;
    logic [IW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    imem_responder #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .DEPTH_WORDS  (DEPTH),
        .LATENCY      (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_fault(rsp_fault),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: at most one outstanding fetch with a countdown of
    // remaining edges, plus the response that is visible to the fetch side.
    logic [31:0] mmem [DEPTH];
    bit          m_pend;
    int          m_left;
    logic [31:0] m_paddr;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    bit          m_fault;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return rst && !flush && ((!m_pend && !m_valid) || (m_valid && rsp_ready));
    endfunction

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic model_clear();
        m_pend  = 0;
        m_left  = 0;
        m_valid = 0;
        m_instr = '0;
        m_addr  = '0;
        m_fault = 0;
    endtask

    task automatic model_edge();
        bit acc;
        acc = req_valid && model_ready();
        if (rst) begin
            if (flush) begin
                m_pend  = 0;
                m_valid = 0;
            end else begin
                if (m_valid && rsp_ready) m_valid = 0;
                if (m_pend) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_pend  = 0;
                        m_valid = 1;
                        m_addr  = m_paddr;
                        m_fault = is_fault(m_paddr);
                        m_instr = m_fault ? NOP : mmem[m_paddr / 4];
                    end
                end
                if (acc) begin
                    m_pend  = 1;
                    m_left  = LAT;
                    m_paddr = req_addr;
                end
            end
        end
        if (ld_en) mmem[ld_addr] = ld_data;
    endtask

    // Let combinational outputs settle after the inputs change, then compare to the model.
    task automatic settle();
        #1;
        check("req_ready", {31'b0, req_ready}, {31'b0, model_ready()});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
        check("rsp_instr", rsp_instr, m_instr);
        check("rsp_addr", rsp_addr, m_addr);
        check("rsp_fault", {31'b0, rsp_fault}, {31'b0, m_fault});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            tick();
        end
    endtask

    task automatic send(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        settle();
        check("send_accept", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    vec_t        vecs [7];
    logic [31:0] old_w;
    logic [31:0] new_w;
    int          r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        model_clear();

        // Reset values while held in reset, with a request offered.
        req_valid = 1'b1;
        idle_ticks(2);
        settle();
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_instr", rsp_instr, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;

        // Program image: fixed words first, random filler after.
        for (int i = 0; i < 64; i++) begin
            ld_en   = 1'b1;
            ld_addr = IW'(i);
            ld_data = (i == 0) ? 32'h0050_0093 :
                      (i == 1) ? 32'h00A0_0113 :
                      (i == 2) ? 32'hDEAD_BEEF : $urandom;
            settle();
            tick();
        end
        idle_inputs();

        // Basic fetch and back-to-back acceptance in the response cycle.
        send(32'h0);
        idle_ticks(LAT - 1);
        settle();
        check("t1_not_yet", {31'b0, rsp_valid}, 32'd0);
        tick();
        req_valid = 1'b1;
        req_addr  = 32'h4;
        settle();
        check("t1_valid", {31'b0, rsp_valid}, 32'd1);
        check("t1_instr", rsp_instr, 32'h0050_0093);
        check("t1_addr", rsp_addr, 32'h0);
        check("t1_fault", {31'b0, rsp_fault}, 32'd0);
        check("t1_b2b_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        idle_ticks(LAT);
        settle();
        check("t2_instr", rsp_instr, 32'h00A0_0113);
        check("t2_addr", rsp_addr, 32'h4);
        tick();

        // Backpressure: hold the response, then accept the next request on release.
        send(32'h8);
        idle_ticks(LAT);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_instr", rsp_instr, 32'hDEAD_BEEF);
            check("bp_addr", rsp_addr, 32'h8);
            check("bp_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        check("bp_release_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        settle();
        check("bp_consumed", {31'b0, rsp_valid}, 32'd0);
        tick();
        idle_ticks(LAT - 1);
        settle();
        check("bp_next_instr", rsp_instr, 32'h0050_0093);
        tick();

        // Directed vector table: in-range, misaligned and out-of-range fetches.
        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{32'h0000_0002, NOP,           1'b1};
        vecs[4] = '{32'h0000_1000, NOP,           1'b1};
        vecs[5] = '{32'hFFFF_FFFC, NOP,           1'b1};
        vecs[6] = '{32'h0000_0007, NOP,           1'b1};
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].addr);
            idle_ticks(LAT);
            settle();
            check("vec_valid", {31'b0, rsp_valid}, 32'd1);
            check("vec_instr", rsp_instr, vecs[i].instr);
            check("vec_addr", rsp_addr, vecs[i].addr);
            check("vec_fault", {31'b0, rsp_fault}, {31'b0, vecs[i].fault});
            tick();
        end

        // Flush in WAIT: the response never appears.
        send(32'h0);
        flush = 1'b1;
        settle();
        check("fw_ready", {31'b0, req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            settle();
            check("fw_no_valid", {31'b0, rsp_valid}, 32'd0);
            tick();
        end

        // Flush in RESP with a request offered: dropped and nothing accepted.
        send(32'h4);
        idle_ticks(LAT);
        rsp_ready = 1'b0;
        flush     = 1'b1;
        req_valid = 1'b1;
        settle();
        check("fr_valid", {31'b0, rsp_valid}, 32'd1);
        check("fr_ready", {31'b0, req_ready}, 32'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        settle();
        check("fr_dropped", {31'b0, rsp_valid}, 32'd0);
        tick();
        idle_ticks(LAT);
        settle();
        check("fr_no_accept", {31'b0, rsp_valid}, 32'd0);
        tick();

        // Flush with a request in IDLE: not accepted.
        req_valid = 1'b1;
        req_addr  = 32'h0;
        flush     = 1'b1;
        settle();
        check("fi_ready", {31'b0, req_ready}, 32'd0);
        tick();
        idle_inputs();
        idle_ticks(LAT + 1);
        settle();
        check("fi_no_valid", {31'b0, rsp_valid}, 32'd0);
        tick();

        // Asynchronous reset mid-WAIT.
        send(32'h4);
        req_valid = 1'b1;
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        check("rw_valid", {31'b0, rsp_valid}, 32'd0);
        check("rw_ready", {31'b0, req_ready}, 32'd0);
        check("rw_instr", rsp_instr, 32'd0);
        tick();
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        settle();
        check("rw_idle_ready", {31'b0, req_ready}, 32'd1);
        check("rw_idle_instr", rsp_instr, 32'd0);
        tick();
        idle_ticks(LAT + 1);

        // Loader write to the captured word on the capture edge.
        old_w = mmem[4];
        new_w = ~old_w ^ 32'h1234_5678;
        send(32'h10);
        idle_ticks(LAT - 1);
        ld_en   = 1'b1;
        ld_addr = IW'(4);
        ld_data = new_w;
        settle();
        tick();
        ld_en = 1'b0;
        settle();
        check("lc_old", rsp_instr, old_w);
        tick();
        send(32'h10);
        idle_ticks(LAT);
        settle();
        check("lc_new", rsp_instr, new_w);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            r         = int'($urandom % 16);
            req_valid = ($urandom % 4) != 0;
            if (r < 12)       req_addr = ($urandom % 64) * 4;
            else if (r < 14)  req_addr = ($urandom % 64) * 4 + 1 + ($urandom % 3);
            else if (r == 14) req_addr = (DEPTH + ($urandom % 1000)) * 4;
            else              req_addr = $urandom | 32'h0001_0000;
            flush     = ($urandom % 20) == 0;
            rsp_ready = ($urandom % 3) != 0;
            ld_en     = ($urandom % 8) == 0;
            ld_addr   = IW'($urandom % 64);
            ld_data   = $urandom;
            settle();
            tick();
        end
        idle_inputs();
        rsp_ready = 1'b1;
        idle_ticks(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
